chan_scan_mux: RTL and testbench

- Parametrised, registered N-channel selector, the successor to the team's 5-input / two-select structural mux demo.
- Channel is chosen either directly by a select bus (manual mode) or by an internal dwell-timed round-robin scanner (scan mode).
- Output is registered and tagged with the channel it came from, so downstream logic and benches can check provenance cycle by cycle.
- Sits between discrete input sources and a single consumer.

---
 rtl/chan_mux_pkg.sv | 9 +
 rtl/dwell_counter.sv | 18 +
 rtl/chan_scan_mux.sv | 59 +++++
 tb/tb_chan_scan_mux.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg: shared state encoding, mode constants and channel wrap helper
package chan_mux_pkg;
    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN = 1'b1;
    function automatic int unsigned wrap_inc(input int unsigned ch, input int unsigned last);
        return (ch == last) ? 0 : ch + 1;
    endfunction
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: modulo-DWELL counter with enable, clear and terminal count
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int CW = $clog2(DWELL + 1);
    logic [CW-1:0] cnt;
    assign tc = cnt == CW'(DWELL - 1);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-channel selector with manual and dwell-timed scan modes
module chan_scan_mux
    import chan_mux_pkg::*;
#(
    parameter int N_CH = 5,
    parameter int W = 1,
    parameter int DWELL = 4,
    localparam int SW = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH*W-1:0] ch_data,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    input  logic            hold,
    output logic [W-1:0]    f_out,
    output logic [SW-1:0]   f_ch,
    output logic            f_valid,
    output logic            sel_err
);
    // highest legal index kept at SW bits so N_CH = 2**SW needs no extra bit
    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);
    state_t state;
    logic [SW-1:0] cur_ch;
    logic scan_stay, tc;
    assign scan_stay = state == SCAN && mode == MODE_SCAN;
    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk(clk),
        .rst(rst),
        .en (scan_stay && !hold),
        .clr(!scan_stay),
        .tc (tc)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cur_ch  <= '0;
            f_out   <= '0;
            f_ch    <= '0;
            f_valid <= 1'b0;
            sel_err <= 1'b0;
        end else if (state == IDLE) begin
            state <= (mode == MODE_SCAN) ? SCAN : MANUAL;
        end else begin
            f_out   <= ch_data[cur_ch*W +: W];
            f_ch    <= cur_ch;
            f_valid <= 1'b1;
            if (mode == MODE_SCAN) begin
                state   <= SCAN;
                sel_err <= 1'b0;
                if (scan_stay && !hold && tc) cur_ch <= SW'(wrap_inc(32'(cur_ch), 32'(LAST)));
            end else begin
                state   <= MANUAL;
                sel_err <= sel > LAST;
                if (sel <= LAST) cur_ch <= sel;
            end
        end
    end
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: directed checks of reset, manual select, range errors, scan wrap, hold and reset
module tb_chan_scan_mux;
    logic clk = 0;
    logic rst, mode, hold;
    logic [4:0] ch_data;
    logic [2:0] sel;
    logic [0:0] f_out;
    logic [2:0] f_ch;
    logic f_valid, sel_err;
    int total = 0;
    int bad = 0;
    chan_scan_mux #(.N_CH(5), .W(1), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .sel(sel), .mode(mode), .hold(hold),
        .f_out(f_out), .f_ch(f_ch), .f_valid(f_valid), .sel_err(sel_err)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    initial begin
        int seq [6] = '{3, 4, 0, 1, 2, 3};
        logic [4:0] dat;
        int ch;
        rst = 1; mode = 0; hold = 0; sel = 0; ch_data = 5'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_valid", 32'(f_valid), 0);
            chk("rst_out", 32'(f_out), 0);
            chk("rst_err", 32'(sel_err), 0);
            ch_data = 5'($urandom);
        end
        ch_data = 5'b01110;
        rst = 0;
        tick;
        chk("idle_valid", 32'(f_valid), 0);
        chk("idle_out", 32'(f_out), 0);
        tick;
        chk("first_valid", 32'(f_valid), 1);
        chk("first_ch", 32'(f_ch), 0);
        sel = 1;
        tick;
        chk("lat1_ch", 32'(f_ch), 0);
        tick;
        chk("sel1_ch", 32'(f_ch), 1);
        chk("sel1_out", 32'(f_out), 1);
        repeat (18) tick;
        sel = 0;
        tick;
        tick;
        chk("sel0_ch", 32'(f_ch), 0);
        chk("sel0_out", 32'(f_out), 0);
        sel = 2;
        tick;
        tick;
        chk("sel2_ch", 32'(f_ch), 2);
        sel = 7;
        tick;
        chk("oor7_err", 32'(sel_err), 1);
        chk("oor7_ch", 32'(f_ch), 2);
        tick;
        chk("oor7_hold", 32'(f_ch), 2);
        sel = 5;
        tick;
        chk("oor5_err", 32'(sel_err), 1);
        tick;
        chk("oor5_hold", 32'(f_ch), 2);
        sel = 4;
        tick;
        chk("sel4_err", 32'(sel_err), 0);
        tick;
        chk("sel4_ch", 32'(f_ch), 4);
        chk("sel4_out", 32'(f_out), 0);
        sel = 3;
        tick;
        tick;
        chk("sel3_ch", 32'(f_ch), 3);
        chk("sel3_out", 32'(f_out), 1);
        chk("sel3_err", 32'(sel_err), 0);
        mode = 1;
        tick;
        dat = ch_data;
        for (int k = 0; k <= 20; k++) begin
            tick;
            ch = seq[k / 4];
            chk("scan_ch", 32'(f_ch), 32'(ch));
            chk("scan_out", 32'(f_out), 32'(dat[ch]));
        end
        hold = 1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) ch_data = 5'b00110;
            tick;
            chk("hold_ch", 32'(f_ch), 3);
            chk("hold_out", 32'(f_out), (k < 5) ? 1 : 0);
        end
        hold = 0;
        for (int k = 1; k <= 3; k++) begin
            tick;
            chk("resume_ch3", 32'(f_ch), 3);
        end
        tick;
        chk("resume_ch4", 32'(f_ch), 4);
        chk("resume_out4", 32'(f_out), 0);
        tick;
        tick;
        mode = 0;
        sel = 2;
        tick;
        chk("expiry_ch", 32'(f_ch), 4);
        tick;
        chk("mode_win_ch", 32'(f_ch), 2);
        chk("mode_win_out", 32'(f_out), 1);
        chk("mode_win_err", 32'(sel_err), 0);
        mode = 1;
        repeat (3) tick;
        chk("prerst_valid", 32'(f_valid), 1);
        chk("prerst_out", 32'(f_out), 1);
        rst = 1;
        tick;
        chk("midrst_valid", 32'(f_valid), 0);
        chk("midrst_out", 32'(f_out), 0);
        chk("midrst_ch", 32'(f_ch), 0);
        chk("midrst_err", 32'(sel_err), 0);
        rst = 0;
        mode = 0;
        sel = 0;
        tick;
        chk("post_idle_valid", 32'(f_valid), 0);
        tick;
        chk("post_valid", 32'(f_valid), 1);
        chk("post_ch", 32'(f_ch), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
